// File: rtl/secure_pkg.sv
// Shared secure-domain types: unlock FSM state encoding and a small sizing helper.
package secure_pkg;

    typedef enum logic [1:0] {
        UL_IDLE    = 2'd0,
        UL_COLLECT = 2'd1,
        UL_GRANT   = 2'd2,
        UL_LOCK    = 2'd3
    } unlock_state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/secure_unlock_ctrl.sv
// Sole driver of `secure`: matches a key sequence on a valid/ready port, then grants for a bounded window.
// Outputs are registered-state decodes (grant 1 cycle after last key); key_ready is low in GRANT and LOCK.
module secure_unlock_ctrl
    import secure_pkg::*;
#(
    parameter int                        KEY_W        = 8,
    parameter int                        NUM_KEYS     = 3,
    parameter logic [KEY_W*NUM_KEYS-1:0] KEY_SEQ      = 24'h7E3CA5,
    parameter int                        GRANT_CYCLES = 4,
    parameter int                        KEY_TIMEOUT  = 8,
    parameter int                        MAX_FAIL     = 3,
    parameter int                        LOCK_CYCLES  = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          key_valid,
    input  logic [KEY_W-1:0]              key_data,
    output logic                          key_ready,
    output logic                          secure,
    output logic                          locked,
    output logic [$clog2(MAX_FAIL+1)-1:0] fail_cnt
);

    localparam int TMR_W = $clog2(max3(KEY_TIMEOUT, GRANT_CYCLES, LOCK_CYCLES) + 1);
    localparam int IDX_W = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
    localparam int FC_W  = $clog2(MAX_FAIL + 1);

    unlock_state_t    state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [FC_W-1:0]  fail_cnt_q, fail_cnt_d;

    logic             accept;
    logic             do_fail;
    logic [KEY_W-1:0] exp_key;
    logic [FC_W-1:0]  fail_inc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= UL_IDLE;
            idx_q      <= '0;
            timer_q    <= '0;
            fail_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            timer_q    <= timer_d;
            fail_cnt_q <= fail_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        timer_d    = timer_q;
        fail_cnt_d = fail_cnt_q;
        do_fail    = 1'b0;
        accept     = key_valid && ((state_q == UL_IDLE) || (state_q == UL_COLLECT));
        exp_key    = KEY_SEQ[KEY_W*int'(idx_q) +: KEY_W];
        fail_inc   = (fail_cnt_q == FC_W'(MAX_FAIL)) ? fail_cnt_q : fail_cnt_q + FC_W'(1);

        case (state_q)
            UL_IDLE, UL_COLLECT: begin
                if (accept) begin
                    if (key_data != exp_key) begin
                        do_fail = 1'b1;
                    end else if (idx_q == IDX_W'(NUM_KEYS - 1)) begin
                        state_d    = UL_GRANT;
                        idx_d      = '0;
                        timer_d    = TMR_W'(GRANT_CYCLES);
                        fail_cnt_d = '0;
                    end else begin
                        state_d = UL_COLLECT;
                        idx_d   = idx_q + IDX_W'(1);
                        timer_d = TMR_W'(KEY_TIMEOUT);
                    end
                end else if (state_q == UL_COLLECT) begin
                    // Idle cycle inside a sequence: expiry counts as one failure.
                    if (timer_q <= TMR_W'(1)) begin
                        do_fail = 1'b1;
                    end else begin
                        timer_d = timer_q - TMR_W'(1);
                    end
                end
            end
            UL_GRANT: begin
                if (timer_q <= TMR_W'(1)) begin
                    state_d = UL_IDLE;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            UL_LOCK: begin
                if (timer_q <= TMR_W'(1)) begin
                    state_d    = UL_IDLE;
                    timer_d    = '0;
                    idx_d      = '0;
                    fail_cnt_d = '0;
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            default: begin
                state_d = UL_IDLE;
                idx_d   = '0;
                timer_d = '0;
            end
        endcase

        if (do_fail) begin
            fail_cnt_d = fail_inc;
            idx_d      = '0;
            if (fail_inc == FC_W'(MAX_FAIL)) begin
                state_d = UL_LOCK;
                timer_d = TMR_W'(LOCK_CYCLES);
            end else begin
                state_d = UL_IDLE;
                timer_d = '0;
            end
        end
    end

    // Pure state decode so secure and locked are mutually exclusive by construction.
    always_comb begin
        key_ready = (state_q == UL_IDLE) || (state_q == UL_COLLECT);
        secure    = (state_q == UL_GRANT);
        locked    = (state_q == UL_LOCK);
        fail_cnt  = fail_cnt_q;
    end

endmodule

// File: tb/tb_secure_unlock_ctrl.sv
// Bench for secure_unlock_ctrl: vector table, directed corner sequences and a random run against a reference model.
module tb_secure_unlock_ctrl;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       key_valid = 1'b0;
    logic [7:0] key_data  = 8'h00;
    logic       key_ready;
    logic       secure;
    logic       locked;
    logic [1:0] fail_cnt;

    int checks   = 0;
    int failures = 0;
    int grants   = 0;

    logic [7:0] seq_k [3] = '{8'hA5, 8'h3C, 8'h7E};

    // Reference: keys matched so far, idle run length, and remaining grant/lock cycles.
    int m_got   = 0;
    int m_idle  = 0;
    int m_fails = 0;
    int m_grant = 0;
    int m_lock  = 0;

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       r;
        logic       s;
        logic       l;
        logic [1:0] f;
    } vec_t;
    vec_t vq[$];

    secure_unlock_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_valid (key_valid),
        .key_data  (key_data),
        .key_ready (key_ready),
        .secure    (secure),
        .locked    (locked),
        .fail_cnt  (fail_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin : model
        int got, idle, fails, gr, lk;
        logic f;
        if (!rst_n) begin
            m_got <= 0; m_idle <= 0; m_fails <= 0; m_grant <= 0; m_lock <= 0;
        end else begin
            got = m_got; idle = m_idle; fails = m_fails; gr = m_grant; lk = m_lock;
            f = 1'b0;
            if (lk > 0) begin
                lk = lk - 1;
                if (lk == 0) fails = 0;
            end else if (gr > 0) begin
                gr = gr - 1;
            end else if (key_valid) begin
                if (key_data == seq_k[got]) begin
                    got = got + 1;
                    idle = 0;
                    if (got == 3) begin
                        got = 0; gr = 4; fails = 0;
                    end
                end else begin
                    f = 1'b1;
                end
            end else if (got > 0) begin
                idle = idle + 1;
                if (idle == 8) f = 1'b1;
            end
            if (f) begin
                fails = fails + 1;
                got = 0;
                idle = 0;
                if (fails == 3) lk = 16;
            end
            m_got <= got; m_idle <= idle; m_fails <= fails; m_grant <= gr; m_lock <= lk;
        end
    end

    task automatic chk(input string nm, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp_v, $time);
        end
    endtask

    task automatic model_check();
        chk("model_ready",  int'(key_ready), int'(m_grant == 0 && m_lock == 0));
        chk("model_secure", int'(secure),    int'(m_grant > 0));
        chk("model_locked", int'(locked),    int'(m_lock > 0));
        chk("model_fail",   int'(fail_cnt),  m_fails);
        chk("excl_sec_lock", int'(secure && locked), 0);
    endtask

    task automatic step(input logic v, input logic [7:0] d);
        key_valid = v;
        key_data  = d;
        @(posedge clk);
        @(negedge clk);
        model_check();
    endtask

    task automatic add(input logic v, input logic [7:0] d, input logic r,
                       input logic s, input logic l, input logic [1:0] f);
        vec_t e;
        e.v = v; e.d = d; e.r = r; e.s = s; e.l = l; e.f = f;
        vq.push_back(e);
    endtask

    initial begin
        // Good sequence, a grant, then a mismatch followed by a recovering sequence.
        add(1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 2'd0);
        add(1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, 2'd0);
        add(1'b1, 8'h7E, 1'b1, 1'b0, 1'b0, 2'd0);
        add(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 2'd0);
        add(1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 2'd0);
        add(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 2'd0);
        add(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 2'd0);
        add(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 2'd0);
        add(1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 2'd0);
        add(1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 2'd0);
        add(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 2'd1);
        add(1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 2'd1);
        add(1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, 2'd1);
        add(1'b1, 8'h7E, 1'b1, 1'b0, 1'b0, 2'd1);
        add(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 2'd0);
        add(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 2'd0);
        add(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 2'd0);
        add(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 2'd0);
        add(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 2'd0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ready",  int'(key_ready), 1);
        chk("reset_secure", int'(secure),    0);
        chk("reset_locked", int'(locked),    0);
        chk("reset_fail",   int'(fail_cnt),  0);
        rst_n = 1'b1;

        foreach (vq[i]) begin
            chk($sformatf("vec%0d_ready", i),  int'(key_ready), int'(vq[i].r));
            chk($sformatf("vec%0d_secure", i), int'(secure),    int'(vq[i].s));
            chk($sformatf("vec%0d_locked", i), int'(locked),    int'(vq[i].l));
            chk($sformatf("vec%0d_fail", i),   int'(fail_cnt),  int'(vq[i].f));
            step(vq[i].v, vq[i].d);
        end

        // Three wrong keys enter lockout; correct keys during lockout are ignored.
        for (int i = 1; i <= 3; i++) begin
            step(1'b1, 8'h00);
            chk("lock_fail_step", int'(fail_cnt), i);
        end
        for (int i = 0; i < 16; i++) begin
            chk("lock_locked", int'(locked),    1);
            chk("lock_ready",  int'(key_ready), 0);
            chk("lock_secure", int'(secure),    0);
            step(1'b1, seq_k[i % 3]);
        end
        chk("lock_exit_locked", int'(locked),    0);
        chk("lock_exit_fail",   int'(fail_cnt),  0);
        chk("lock_exit_ready",  int'(key_ready), 1);
        step(1'b0, 8'h00);

        // Inter-key timeout: failure lands on the eighth idle cycle.
        step(1'b1, 8'hA5);
        for (int i = 1; i <= 9; i++) begin
            step(1'b0, 8'h00);
            chk("timeout_fail",   int'(fail_cnt), (i >= 8) ? 1 : 0);
            chk("timeout_secure", int'(secure),   0);
        end

        // Gaps of up to seven idle cycles still complete a sequence.
        step(1'b1, 8'hA5);
        repeat (7) step(1'b0, 8'h00);
        step(1'b1, 8'h3C);
        repeat (3) step(1'b0, 8'h00);
        step(1'b1, 8'h7E);
        chk("gap_grant",      int'(secure),   1);
        chk("gap_fail_clear", int'(fail_cnt), 0);
        repeat (4) step(1'b0, 8'h00);

        // Reset asserted on the second grant cycle.
        step(1'b1, 8'h00);
        step(1'b1, 8'hA5);
        step(1'b1, 8'h3C);
        step(1'b1, 8'h7E);
        chk("rst_grant_c1", int'(secure), 1);
        step(1'b0, 8'h00);
        chk("rst_grant_c2", int'(secure), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid_secure", int'(secure),    0);
        chk("rst_mid_locked", int'(locked),    0);
        chk("rst_mid_ready",  int'(key_ready), 1);
        chk("rst_mid_fail",   int'(fail_cnt),  0);
        @(negedge clk);
        rst_n = 1'b1;
        model_check();
        step(1'b1, 8'hA5);
        step(1'b1, 8'h3C);
        step(1'b1, 8'h7E);
        for (int i = 0; i < 4; i++) begin
            chk("post_rst_grant", int'(secure), 1);
            step(1'b0, 8'h00);
        end
        chk("post_rst_idle", int'(secure), 0);

        // Random traffic biased toward the expected next key, with occasional long gaps.
        for (int c = 0; c < 3000; c++) begin
            logic       v;
            logic [7:0] d;
            if ($urandom_range(0, 39) == 0) begin
                for (int g = 0; g < 10; g++) step(1'b0, 8'h00);
            end
            v = ($urandom_range(0, 99) < 55);
            d = ($urandom_range(0, 3) != 0) ? seq_k[m_got] : 8'($urandom);
            step(v, d);
            if (secure) grants++;
        end
        chk("rand_grant_seen", int'(grants > 0), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
